mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - MEM-stage data-memory controller of the 5-stage 16-bit pipeline; sits directly upstream of the MEM/WB register.
// - Turns pipeline load/store requests into a single-request handshake with a multi-cycle data memory.
// - Drives stall_MEM, which freezes upstream stages and suppresses regWrite into MEM/WB while an access is pending.
// - Returns load data and flags misaligned accesses.
// PARAMETERS
// - DATA_W   16  data width of the memory port and pipeline data
// - ADDR_W   16  byte-address width
// - TIMEOUT  64  max WAIT cycles before timeout error (used only with MEM_TIMEOUT_EN)
// PORTS
// - clk             in   1       clock; all state updates on rising edge
// - rst             in   1       synchronous, active-high reset
// - valid_MEM       in   1       instruction in MEM stage is valid (not a bubble)
// - memRead_MEM     in   1       load
// - memWrite_MEM    in   1       store (memRead_MEM & memWrite_MEM together is illegal; treated as store)
// - halt_MEM        in   1       HALT in MEM; no access issued
// - ALU_result_MEM  in   ADDR_W  effective byte address
// - write_data_MEM  in   DATA_W  store data
// - read_data_MEM   out  DATA_W  registered load data, to MEM/WB
// - stall_MEM       out  1       pipeline stall request
// - err_MEM         out  1       sticky error (misaligned / timeout)
// - mem_en          out  1       memory request strobe, 1 cycle per access
// - mem_wr          out  1       1=write, 0=read; valid with mem_en
// - mem_addr        out  ADDR_W  request address; valid with mem_en
// - mem_wdata       out  DATA_W  write data; valid with mem_en
// - mem_rdata       in   DATA_W  read data; valid when mem_done=1
// - mem_done        in   1       access complete; ignored outside WAIT
// BEHAVIOUR
// - FSM states IDLE, WAIT, DONE. Reset: state=IDLE; read_data_MEM=0; err_MEM=0; mem_en=0; mem_wr=0; mem_addr=0; mem_wdata=0; stall_MEM=0.
// - IDLE: access = valid_MEM & (memRead_MEM|memWrite_MEM) & ~halt_MEM & ~ALU_result_MEM[0] & ~err_MEM.
//   On access: mem_en=1 combinationally for this cycle; mem_wr/addr/wdata driven from inputs; stall_MEM=1; next WAIT.
// - WAIT: mem_en=0; stall_MEM=1. If mem_done: read_data_MEM <= mem_rdata (loads only, stores keep value); next DONE.
// - DONE: stall_MEM=0; read_data_MEM stable; next IDLE unconditionally. Prevents re-issuing the same instruction.
// - Minimum access latency 3 cycles (issue, done, release). Stall deasserts the cycle after mem_done.
// - Misaligned (valid & rd|wr & addr[0]=1) in IDLE: no request; err_MEM <= 1 next edge; stall_MEM=0.
// - err_MEM is sticky until rst. While set, no further requests are issued.
// - Non-memory, bubble, or halt instructions pass with stall_MEM=0 and read_data_MEM unchanged.
// - rst mid-access (WAIT): returns to IDLE; the in-flight memory result is dropped; the memory must tolerate an abandoned request.
// - mem_done asserted in IDLE/DONE is ignored.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined: a wait counter clears on entry to WAIT and increments each WAIT cycle.
//   If it reaches TIMEOUT without mem_done: err_MEM <= 1, next IDLE, stall released.
//   mem_done in the same cycle as the terminal count wins (normal DONE path).
// - MEM_TIMEOUT_EN undefined: no counter; WAIT persists until mem_done; TIMEOUT unused.
// STRUCTURE
// - mem_pkg: state enum {IDLE=2'd0, WAIT=2'd1, DONE=2'd2}; localparams for access type (RD, WR).
// - One sub-module: mem_wait_timer (counter + terminal-count compare), instantiated only under MEM_TIMEOUT_EN.
// - Everything else is flat: FSM register, read-data register, sticky error flop.
// TESTING
// - Load at 0x0010, mem_done 2 cycles after mem_en, rdata=0xBEEF -> stall_MEM high 3 cycles; read_data_MEM=0xBEEF in DONE.
// - Store 0x1234 to 0x0020, mem_done next cycle -> mem_en 1 cycle, mem_wr=1; read_data_MEM unchanged; stall 2 cycles.
// - Load at 0x0011 -> no mem_en; err_MEM=1 next cycle; later valid load at 0x0010 issues no request.
// - Back-to-back loads 0x0002 then 0x0004 -> exactly two mem_en pulses; separated by DONE+IDLE; no duplicate issue.
// - rst asserted in WAIT, then mem_done -> state IDLE, outputs at reset values, mem_done ignored.
// - MEM_TIMEOUT_EN, TIMEOUT=4, no mem_done -> err_MEM=1 after 4 WAIT cycles; stall_MEM drops the same edge.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage data-memory controller: FSM state encoding and access-type codes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the memory controller; flags the last permitted WAIT cycle.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of WAIT cycles already spent, so this is the TIMEOUT-th one
    assign tc = en & (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: single-request handshake, pipeline stall, load data and sticky error.
// Optional MEM_TIMEOUT_EN adds a WAIT-cycle timeout that raises err_MEM.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_MEM,
    input  logic              memRead_MEM,
    input  logic              memWrite_MEM,
    input  logic              halt_MEM,
    input  logic [ADDR_W-1:0] ALU_result_MEM,
    input  logic [DATA_W-1:0] write_data_MEM,
    output logic [DATA_W-1:0] read_data_MEM,
    output logic              stall_MEM,
    output logic              err_MEM,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    state_t state, state_nxt;
    logic   op_q;
    logic   req, misalign, access, timeout_hit;

    assign req      = valid_MEM & (memRead_MEM | memWrite_MEM);
    assign misalign = req & ALU_result_MEM[0];
    assign access   = req & ~halt_MEM & ~ALU_result_MEM[0] & ~err_MEM;

`ifdef MEM_TIMEOUT_EN
    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk(clk),
        .rst(rst),
        .clr((state == IDLE) & access),
        .en (state == WAIT),
        .tc (timeout_hit)
    );
`else
    // Without the timer build WAIT only ends on mem_done
    localparam logic TMO_CFG = (TIMEOUT > 0);
    assign timeout_hit = TMO_CFG & 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_wr    = RD;
        mem_addr  = '0;
        mem_wdata = '0;
        stall_MEM = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    mem_en    = 1'b1;
                    mem_wr    = memWrite_MEM ? WR : RD;
                    mem_addr  = ALU_result_MEM;
                    mem_wdata = write_data_MEM;
                    stall_MEM = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall_MEM = 1'b1;
                if (mem_done) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset wins over any request presented in the same cycle
        if (rst) begin
            mem_en    = 1'b0;
            mem_wr    = RD;
            mem_addr  = '0;
            mem_wdata = '0;
            stall_MEM = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op_q          <= RD;
            read_data_MEM <= '0;
            err_MEM       <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && access) begin
                op_q <= mem_wr;
            end
            if ((state == WAIT) && mem_done && (op_q == RD)) begin
                read_data_MEM <= mem_rdata;
            end
            if (((state == IDLE) && misalign) ||
                ((state == WAIT) && !mem_done && timeout_hit)) begin
                err_MEM <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scripted pipeline requests, request scoreboard on mem_en.
// Define MEM_TIMEOUT_EN to also exercise the timeout path (TIMEOUT=4).
module tb_mem_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid, rd, wr, halt, done;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic [DW-1:0] read_data;
    logic          stall, err, mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    req_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_req    = 0;
    int   n_push   = 0;

    mem_access_ctrl #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_MEM     (valid),
        .memRead_MEM   (rd),
        .memWrite_MEM  (wr),
        .halt_MEM      (halt),
        .ALU_result_MEM(addr),
        .write_data_MEM(wdata),
        .read_data_MEM (read_data),
        .stall_MEM     (stall),
        .err_MEM       (err),
        .mem_en        (mem_en),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (rdata),
        .mem_done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every request strobe must match the next expected request in order
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            req_t e;
            n_req++;
            if (exp_q.size() == 0) begin
                check("req_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("req_wr", {31'd0, mem_wr}, {31'd0, e.wr});
                check("req_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                check("req_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        valid = 1'b0; rd = 1'b0; wr = 1'b0; halt = 1'b0;
        addr = '0; wdata = '0; done = 1'b0;
    endtask

    task automatic drive_ld(input logic [AW-1:0] a);
        valid = 1'b1; rd = 1'b1; wr = 1'b0; halt = 1'b0;
        addr = a; wdata = '0;
        exp_q.push_back('{wr: 1'b0, addr: a, wdata: '0});
        n_push++;
    endtask

    task automatic drive_st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid = 1'b1; rd = 1'b0; wr = 1'b1; halt = 1'b0;
        addr = a; wdata = d;
        exp_q.push_back('{wr: 1'b1, addr: a, wdata: d});
        n_push++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        step();
        step();
        smp();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_rdata", {16'd0, read_data}, 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rdata = '0;
        idle_in();
        step();
        smp();
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        do_reset();

        // Load at 0x0010, mem_done two cycles after the request
        drive_ld(16'h0010);
        smp(); check("ld_stall_issue", {31'd0, stall}, 32'd1);
        step();
        smp(); check("ld_stall_wait1", {31'd0, stall}, 32'd1);
        step();
        done = 1'b1; rdata = 16'hBEEF;
        smp(); check("ld_stall_wait2", {31'd0, stall}, 32'd1);
        step();
        done = 1'b0; rdata = '0;
        smp(); check("ld_stall_done", {31'd0, stall}, 32'd0);
        check("ld_rdata_done", {16'd0, read_data}, 32'h0000BEEF);
        step();
        idle_in();
        smp(); check("ld_rdata_hold", {16'd0, read_data}, 32'h0000BEEF);
        step();

        // Store 0x1234 to 0x0020, mem_done the next cycle; load data must not move
        drive_st(16'h0020, 16'h1234);
        smp(); check("st_stall_issue", {31'd0, stall}, 32'd1);
        step();
        done = 1'b1; rdata = 16'h5555;
        smp(); check("st_stall_wait", {31'd0, stall}, 32'd1);
        step();
        done = 1'b0;
        smp(); check("st_stall_done", {31'd0, stall}, 32'd0);
        check("st_rdata_keep", {16'd0, read_data}, 32'h0000BEEF);
        step();
        idle_in();

        // Non-memory, halt and bubble pass through; mem_done in IDLE is ignored
        valid = 1'b1;
        smp(); check("nonmem_stall", {31'd0, stall}, 32'd0);
        step();
        rd = 1'b1; addr = 16'h0040; halt = 1'b1;
        smp(); check("halt_stall", {31'd0, stall}, 32'd0);
        step();
        valid = 1'b0; halt = 1'b0; done = 1'b1; rdata = 16'hDEAD;
        smp(); check("bubble_stall", {31'd0, stall}, 32'd0);
        step();
        idle_in();
        smp(); check("idle_done_ignored", {16'd0, read_data}, 32'h0000BEEF);
        step();

        // Back-to-back loads: inputs held through DONE must not re-issue
        drive_ld(16'h0002);
        smp(); check("b2b_a_issue", {31'd0, stall}, 32'd1);
        step();
        done = 1'b1; rdata = 16'h1111;
        smp();
        step();
        done = 1'b0;
        smp(); check("b2b_a_done", {31'd0, stall}, 32'd0);
        check("b2b_a_rdata", {16'd0, read_data}, 32'h00001111);
        step();
        drive_ld(16'h0004);
        smp(); check("b2b_b_issue", {31'd0, stall}, 32'd1);
        step();
        done = 1'b1; rdata = 16'h2222;
        smp();
        step();
        done = 1'b0;
        smp(); check("b2b_b_rdata", {16'd0, read_data}, 32'h00002222);
        step();
        idle_in();

        // Reset while waiting: late mem_done is dropped
        drive_ld(16'h0030);
        smp();
        step();
        rst = 1'b1;
        idle_in();
        smp(); check("rstw_stall", {31'd0, stall}, 32'd0);
        step();
        rst = 1'b0; done = 1'b1; rdata = 16'hAAAA;
        smp(); check("rstw_stall_after", {31'd0, stall}, 32'd0);
        check("rstw_rdata", {16'd0, read_data}, 32'd0);
        step();
        done = 1'b0;
        smp(); check("rstw_drop", {16'd0, read_data}, 32'd0);
        step();

        // Misaligned load sets the sticky error and blocks later requests
        valid = 1'b1; rd = 1'b1; addr = 16'h0011;
        smp(); check("mis_stall", {31'd0, stall}, 32'd0);
        check("mis_err_pre", {31'd0, err}, 32'd0);
        step();
        idle_in();
        smp(); check("mis_err", {31'd0, err}, 32'd1);
        step();
        valid = 1'b1; rd = 1'b1; addr = 16'h0010;
        smp(); check("err_block_stall", {31'd0, stall}, 32'd0);
        step();
        idle_in();
        smp(); check("err_sticky", {31'd0, err}, 32'd1);
        step();

`ifdef MEM_TIMEOUT_EN
        // No mem_done: the fourth WAIT cycle ends the access with an error
        do_reset();
        drive_ld(16'h0040);
        smp(); check("tmo_issue", {31'd0, stall}, 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            smp(); check("tmo_wait_stall", {31'd0, stall}, 32'd1);
            check("tmo_wait_err", {31'd0, err}, 32'd0);
            step();
        end
        idle_in();
        smp(); check("tmo_stall_drop", {31'd0, stall}, 32'd0);
        check("tmo_err", {31'd0, err}, 32'd1);
        step();
`endif

        smp();
        check("req_count", n_req, n_push);
        check("req_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
